// File: rtl/sync_ram_be.sv
// Parametrised single-port synchronous RAM with per-byte write enables, registered
// read with valid/err flags, selectable read-during-write mode and a post-reset clear engine.

module sync_ram_be_lane #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [DEPTH];

  // Array is never reset; the clear engine zeroes it through the normal write port.
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module sync_ram_be #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  rw,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  err
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;

  logic [ADDR_W-1:0]               clr_cnt;
  logic                            clearing, acc, in_range;
  logic [ADDR_W-1:0]               mem_addr;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][7:0]       lane_wdata, lane_old, lane_new;

  assign clearing = (state == CLEAR);
  assign busy     = clearing;
  assign acc      = en & ~clearing;
  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign mem_addr = clearing ? clr_cnt : addr;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i]    = clearing | (acc & rw & in_range & be[i]);
    assign lane_wdata[i] = clearing ? 8'h00 : din[8*i +: 8];
    assign lane_new[i]   = be[i] ? din[8*i +: 8] : lane_old[i];

    sync_ram_be_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .addr  (mem_addr),
      .wdata (lane_wdata[i]),
      .rdata (lane_old[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= acc;
      err        <= acc & ~in_range;
      if (clearing) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST) state <= IDLE;
      end
      // Write-first returns the merged word; out-of-range accesses return zero.
      if (acc)
        dout <= !in_range ? '0 : (rw && RDW_MODE != 0) ? lane_new : lane_old;
    end
  end
endmodule

// File: tb/tb_sync_ram_be.sv
// Scoreboarded bench for sync_ram_be: read-first, write-first and DEPTH=200 instances
// share one stimulus stream; expected words come from a behavioural memory model.

module tb_sync_ram_be;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1, en = 1'b0, rw = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] din = '0;
  logic [3:0]  be = '0;

  logic [31:0] dout0, dout1, dout2;
  logic        dv0, dv1, dv2, busy0, busy1, busy2, err0, err1, err2;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [31:0] d0, d1, d2;
    logic        e2;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] m0 [256];
  logic [31:0] m2 [256];
  logic [101:0] obs;

  assign obs = {dv0, dv1, dv2, dout0, dout1, dout2, err0, err1, err2};

  always #5 clk = ~clk;

  sync_ram_be #(.RDW_MODE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .en(en), .rw(rw), .addr(addr),
    .din(din), .be(be), .dout(dout0), .dout_valid(dv0), .busy(busy0), .err(err0));
  sync_ram_be #(.RDW_MODE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .en(en), .rw(rw), .addr(addr),
    .din(din), .be(be), .dout(dout1), .dout_valid(dv1), .busy(busy1), .err(err1));
  sync_ram_be #(.DEPTH(200))  u_dut2 (.clk(clk), .rst_n(rst_n), .en(en), .rw(rw), .addr(addr),
    .din(din), .be(be), .dout(dout2), .dout_valid(dv2), .busy(busy2), .err(err2));

  function automatic logic [101:0] expv(exp_t x);
    return {3'b111, x.d0, x.d1, x.d2, 2'b00, x.e2};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin m0[i] = '0; m2[i] = '0; end
  endtask

  // Drives one cycle; accepted accesses push their expected response and update the model.
  task automatic drive(input logic e, input logic r, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    exp_t x;
    en = e; rw = r; addr = a; din = d; be = b;
    if (e) begin
      x.e2 = (a >= 8'd200);
      x.d0 = m0[a];
      x.d1 = r ? merge(m0[a], d, b) : m0[a];
      x.d2 = x.e2 ? 32'h0 : m2[a];
      if (r) begin
        m0[a] = merge(m0[a], d, b);
        if (!x.e2) m2[a] = merge(m2[a], d, b);
      end
      sbq.push_back(x);
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    exp_t x;
    int cnt, c2;
    #2 rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({busy0, busy1, busy2, dv0, dv1, dv2, err0, err2, dout0, dout1, dout2} !== {3'b111, 5'b0, 96'b0}) begin
      n_bad++; $display("FAIL reset_state got busy=%b%b%b dv=%b%b%b dout=%h exp busy=111 dv=000 dout=0",
                        busy0, busy1, busy2, dv0, dv1, dv2, dout0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0; c2 = 0;
    while (busy0 && cnt < 1000) begin
      en = (cnt < 190) && ((cnt % 37 == 5) || (cnt > 150 && cnt < 155));
      rw = (cnt > 150 && cnt < 155);
      addr = rw ? 8'h05 : 8'h37; din = 32'hFFFF_FFFF; be = 4'hF;
      @(posedge clk); #1; cnt++;
      if (!busy2 && c2 == 0) c2 = cnt;
      n_cmp++;
      if ({dv0, dv1, dv2, err0, err2} !== 5'b0) begin
        n_bad++; $display("FAIL busy_ignore cyc=%0d got dv=%b%b%b err=%b%b exp 0", cnt, dv0, dv1, dv2, err0, err2);
      end
    end
    en = 1'b0;
    n_cmp++;
    if (cnt != 256 || c2 != 200) begin
      n_bad++; $display("FAIL clear_len got %0d/%0d exp 256/200", cnt, c2);
    end
    model_clear();
    drive(1, 0, 8'h05, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x)) begin n_bad++; $display("FAIL busy_write_dropped got %h exp %h", obs, expv(x)); end
    drive(1, 1, 8'h37, 32'h1234_5678, 4'hF);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x)) begin n_bad++; $display("FAIL prefill_wr got %h exp %h", obs, expv(x)); end
    // Second reset with a non-zero word in memory: the clear must wipe it.
    rst_n = 1'b0; #2; @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    while (busy0 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
    n_cmp++;
    if (cnt != 256) begin n_bad++; $display("FAIL clear_len2 got %0d exp 256", cnt); end
    model_clear();
    drive(1, 0, 8'h37, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || dout0 !== 32'h0) begin
      n_bad++; $display("FAIL cleared_rd got %h exp %h", obs, expv(x));
    end
  endtask

  task automatic test_full_word();
    exp_t x;
    drive(1, 1, 8'h10, 32'hDEAD_BEEF, 4'hF);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x)) begin n_bad++; $display("FAIL fw_wr got %h exp %h", obs, expv(x)); end
    drive(1, 0, 8'h10, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || dout0 !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL fw_rd got %h exp %h", obs, expv(x));
    end
    drive(0, 0, 8'h44, 32'h5555_5555, 4'hF);
    n_cmp++;
    if ({dv0, err0, dout0} !== {2'b00, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL idle_hold got dv=%b err=%b dout=%h exp 0 0 deadbeef", dv0, err0, dout0);
    end
  endtask

  task automatic test_byte_en();
    exp_t x;
    drive(1, 1, 8'h10, 32'h1122_3344, 4'b0101);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || dout1 !== 32'hDE22_BE44) begin
      n_bad++; $display("FAIL be_wr got %h exp %h", obs, expv(x));
    end
    drive(1, 1, 8'h10, 32'hFFFF_FFFF, 4'b0000);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x)) begin n_bad++; $display("FAIL be0_wr got %h exp %h", obs, expv(x)); end
    drive(1, 0, 8'h10, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || dout0 !== 32'hDE22_BE44) begin
      n_bad++; $display("FAIL be_rd got %h exp %h", obs, expv(x));
    end
  endtask

  task automatic test_rdw();
    exp_t x;
    drive(1, 1, 8'h20, 32'hCAFE_F00D, 4'hF);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || {dout0, dout1} !== {32'h0, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL rdw_wr got %h exp %h", obs, expv(x));
    end
    drive(1, 0, 8'h20, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || dout0 !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL rdw_b2b_rd got %h exp %h", obs, expv(x));
    end
  endtask

  task automatic test_sweep();
    exp_t x;
    logic [7:0] a;
    a = 8'h80;
    for (int i = 0; i < 256; i++) begin
      drive(1, 1, a, $urandom, 4'($urandom_range(0, 15)));
      x = sbq.pop_front(); n_cmp++;
      if (obs !== expv(x)) begin n_bad++; $display("FAIL sweep_wr a=%h got %h exp %h", a, obs, expv(x)); end
      a++;
    end
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, a, 0, 0);
      x = sbq.pop_front(); n_cmp++;
      if (obs !== expv(x)) begin n_bad++; $display("FAIL sweep_rd a=%h got %h exp %h", a, obs, expv(x)); end
      a++;
    end
  endtask

  task automatic test_range_reset();
    exp_t x;
    int cnt, c2;
    drive(1, 1, 8'd210, 32'h0BAD_0BAD, 4'hF);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || {err2, dout2} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL oor_wr got %h exp %h", obs, expv(x));
    end
    drive(1, 0, 8'd210, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x) || {err2, dout2} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL oor_rd got %h exp %h", obs, expv(x));
    end
    drive(1, 0, 8'h20, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x)) begin n_bad++; $display("FAIL pre_rst_rd got %h exp %h", obs, expv(x)); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dv0, dv2, err2, dout0, dout2} !== 67'b0) begin
      n_bad++; $display("FAIL rst_midaccess got dv=%b%b dout=%h/%h exp 0", dv0, dv2, dout0, dout2);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy0, busy2} !== 2'b11) begin n_bad++; $display("FAIL rst_midclear got busy=%b%b exp 11", busy0, busy2); end
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0; c2 = 0;
    while (busy0 && cnt < 1000) begin
      @(posedge clk); #1; cnt++;
      if (!busy2 && c2 == 0) c2 = cnt;
    end
    n_cmp++;
    if (cnt != 256 || c2 != 200) begin n_bad++; $display("FAIL restart_clear_len got %0d/%0d exp 256/200", cnt, c2); end
    model_clear();
    drive(1, 0, 8'h20, 0, 0);
    x = sbq.pop_front(); n_cmp++;
    if (obs !== expv(x)) begin n_bad++; $display("FAIL post_restart_rd got %h exp %h", obs, expv(x)); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_word();
    test_byte_en();
    test_rdw();
    test_sweep();
    test_range_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_ram_be.md
Name: sync_ram_be

Overview:
Parametrised single-port synchronous RAM, the successor to the fixed 256x32 RAM. Adds configurable width and depth, per-byte write enables, a registered read with a valid flag, a selectable read-during-write mode and an on-reset memory clear engine. Sits behind the datapath/memory controller as general-purpose data storage.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 8, address width in bits.
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
RDW_MODE, 0, write-cycle dout: 0 = read-first (old word), 1 = write-first (merged new word).
CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no clear.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  access request; sampled on rising edge.
rw  in  1  1 = write, 0 = read.
addr  in  ADDR_W  word address.
din  in  DATA_W  write data.
be  in  DATA_W/8  byte write enables; bit i controls din[8i+7:8i].
dout  out  DATA_W  registered read data.
dout_valid  out  1  dout updated by the access accepted on the previous edge.
busy  out  1  clear engine running; accesses are not accepted.
err  out  1  out-of-range access flag, aligned with dout_valid.

Behaviour:
- Asynchronous reset (rst_n low): dout=0, dout_valid=0, err=0, clear counter=0.
  - FSM enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy=1 in CLEAR, 0 in IDLE.
  - The memory array is not reset directly.
- FSM has two states: CLEAR and IDLE.
  - CLEAR: each cycle, writes 0 to word clr_cnt, then increments clr_cnt.
  - The write with clr_cnt == DEPTH-1 is the last; the next state is IDLE.
  - CLEAR lasts exactly DEPTH cycles after rst_n deasserts.
  - IDLE is terminal until the next reset.
- Reset asserted mid-CLEAR restarts the clear from word 0 after release.
- Accept condition: en=1 and busy=0.
  - While busy, en is ignored: no write, dout holds, dout_valid=0, err=0.
- Accepted read: on edge N, dout <= mem[addr]; dout_valid=1 during cycle N+1 only. Latency is 1 cycle.
- Accepted write:
  - For each lane i with be[i]=1, mem[addr] lane i <= din lane i. Lanes with be[i]=0 are unchanged.
  - be=0 is a legal no-op write that still produces dout_valid.
  - dout <= old word if RDW_MODE=0, or the merged new word if RDW_MODE=1.
  - dout_valid=1 during the next cycle.
- Out-of-range access (addr >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Write is dropped; memory is unchanged.
  - Read returns dout=0.
  - dout_valid=1 and err=1 for one cycle.
- No accepted access (en=0): dout holds its last value; dout_valid=0, err=0.
- Back-to-back accesses are allowed, one per cycle. A read at address A on the cycle after a write to A returns the written data.
- Address arithmetic does not wrap internally. Callers that increment addr wrap at 2**ADDR_W naturally.
- Reset asserted mid-access: the in-flight dout/dout_valid/err are cleared immediately. Memory contents of a write not yet clocked are unchanged.

Test Plan:
1. Reset/clear (defaults, pre-filled memory): release rst_n -> busy=1 for exactly 256 cycles; en pulses during busy give dout_valid=0. Afterwards, read 0x37 -> dout=0x00000000 with dout_valid one cycle later.
2. Full word: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> dout=0xDEADBEEF one cycle after the read edge, dout_valid a single-cycle pulse.
3. Byte enables: with 0x10=0xDEADBEEF, write 0x11223344 with be=4'b0101 -> read 0x10 = 0xDE22BE44. A be=0 write leaves the value unchanged and still pulses dout_valid.
4. Read-during-write: write 0xCAFEF00D to 0x20 (old value 0x0) -> write-cycle dout=0x00000000 for RDW_MODE=0, 0xCAFEF00D for RDW_MODE=1. Back-to-back read of 0x20 -> 0xCAFEF00D.
5. Sweep: write random data to all 256 addresses with addr incrementing and wrapping 0xFF->0x00, then switch to reads and sweep again -> every dout matches the scoreboard; 0x00 is not overwritten by the wrap.
6. Range/reset (DEPTH=200): write to addr 210 -> err=1 with dout_valid and no memory change; read 210 -> dout=0, err=1. Assert rst_n low at clear cycle 100 -> after release busy lasts a full 200 cycles.
